// File: rtl/lcd_pkg.sv
// lcd_pkg: shared scan types, digit width and sizing helpers
package lcd_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic {BLANK, SHOW} scan_state_t;
  function automatic int ticks(int clk_hz, int scan_hz);
    return clk_hz / scan_hz;
  endfunction
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lcd_scan_if.sv
// lcd_scan_if: host-side value/mask/update inputs and decoder-side scan outputs
interface lcd_scan_if import lcd_pkg::*; #(parameter int DIGITS = 8);
  logic [DIGIT_W*DIGITS-1:0] data;
  logic [DIGITS-1:0] mask;
  logic update;
  logic [DIGIT_W-1:0] nibble;
  logic nibble_en;
  logic [DIGITS-1:0] digit_sel;
  logic frame_done;
  modport master (output data, mask, update, input nibble, nibble_en, digit_sel, frame_done);
  modport slave (input data, mask, update, output nibble, nibble_en, digit_sel, frame_done);
endinterface

// File: rtl/lcd_scan_timer.sv
// lcd_scan_timer: per-slot tick counter with dead-time-end and slot-end strobes
module lcd_scan_timer import lcd_pkg::*; #(
  parameter int TICKS = 10,
  parameter int BLANK_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  output logic blank_end,
  output logic slot_end
);
  localparam int CW = cnt_w(TICKS);
  logic [CW-1:0] tick_cnt;
  assign blank_end = tick_cnt == CW'(BLANK_CYC - 1);
  assign slot_end = tick_cnt == CW'(TICKS - 1);
  // count 0..TICKS-1 and wrap
  always_ff @(posedge clk)
    if (rst || slot_end) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + CW'(1);
endmodule

// File: rtl/lcd_scan.sv
// lcd_scan: multiplexed digit scanner with tear-free shadow buffer and dead-time; LCD_SCAN_LZB_EN enables leading-zero blanking
module lcd_scan import lcd_pkg::*; #(
  parameter int DIGITS = 8,
  parameter int CLK_HZ = 50000000,
  parameter int SCAN_HZ = 1000,
  parameter int BLANK_CYC = 16
) (
  input logic clk,
  input logic rst,
  lcd_scan_if.slave bus
);
  localparam int TICKS = ticks(CLK_HZ, SCAN_HZ);
  localparam int IW = cnt_w(DIGITS);
  scan_state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DIGIT_W*DIGITS-1:0] staging, shadow;
  logic [DIGITS-1:0] stage_mask, shadow_mask;
  logic pending, blank_end, slot_end, boundary, en_c;

  lcd_scan_timer #(.TICKS(TICKS), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk),
    .rst(rst),
    .blank_end(blank_end),
    .slot_end(slot_end)
  );

`ifdef LCD_SCAN_LZB_EN
  logic [IW-1:0] hi;
  // highest nonzero digit of the shown value; digit 0 when all zero
  always_comb begin
    hi = '0;
    for (int i = 0; i < DIGITS; i++) if (shadow[DIGIT_W*i +: DIGIT_W] != '0) hi = IW'(i);
  end
  assign en_c = shadow_mask[idx] && idx <= hi;
`else
  assign en_c = shadow_mask[idx];
`endif

  // next state and digit index; idx only moves on SHOW->BLANK
  always_comb begin
    boundary = slot_end && idx == IW'(DIGITS - 1);
    idx_nxt = slot_end ? (boundary ? '0 : idx + IW'(1)) : idx;
    state_nxt = state == BLANK && blank_end ? SHOW : (state == SHOW && slot_end ? BLANK : state);
  end

  // scan state and digit index registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= BLANK;
      idx <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
    end

  // staging/shadow buffering: shadow changes only at a frame boundary
  always_ff @(posedge clk)
    if (rst) begin
      staging <= '0;
      stage_mask <= '0;
      shadow <= '0;
      shadow_mask <= '0;
      pending <= 1'b0;
    end else if (boundary && bus.update) begin
      shadow <= bus.data;
      shadow_mask <= bus.mask;
      pending <= 1'b0;
    end else if (bus.update) begin
      staging <= bus.data;
      stage_mask <= bus.mask;
      pending <= 1'b1;
    end else if (boundary && pending) begin
      shadow <= staging;
      shadow_mask <= stage_mask;
      pending <= 1'b0;
    end

  // registered decoder and common-select outputs
  always_ff @(posedge clk)
    if (rst) begin
      bus.nibble <= '0;
      bus.nibble_en <= 1'b0;
      bus.digit_sel <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= boundary;
      bus.digit_sel <= state_nxt == SHOW ? ~(DIGITS'(1) << idx) : '1;
      bus.nibble_en <= state_nxt == SHOW && en_c;
      if (state_nxt == SHOW) bus.nibble <= shadow[DIGIT_W*idx +: DIGIT_W];
    end
endmodule

// File: tb/tb_lcd_scan.sv
// tb_lcd_scan: scoreboard bench for lcd_scan (DIGITS=4, TICKS=10, BLANK_CYC=2); honours LCD_SCAN_LZB_EN
module tb_lcd_scan;
  typedef struct packed {logic [3:0] nib; logic en;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t cur;
  logic [15:0] last_d = '0;
  logic [3:0] last_m = '0;

  lcd_scan_if #(.DIGITS(4)) bus ();
  lcd_scan #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [15:0] d, input logic [3:0] m);
    exp_t e;
`ifdef LCD_SCAN_LZB_EN
    int hi = 0;
    for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'h0) hi = i;
`endif
    for (int i = 0; i < 4; i++) begin
      e.nib = d[4*i +: 4];
`ifdef LCD_SCAN_LZB_EN
      e.en = m[i] && i <= hi;
`else
      e.en = m[i];
`endif
      q.push_back(e);
    end
    last_d = d;
    last_m = m;
  endtask

  task automatic check_idle(input string name, input logic [3:0] nib_e);
    checks++;
    if (bus.digit_sel !== 4'hF || bus.nibble_en !== 1'b0 || bus.frame_done !== 1'b0 || bus.nibble !== nib_e) begin
      failures++;
      $display("FAIL %s sel=%b want 1111 en=%b want 0 fd=%b want 0 nib=%h want %h", name, bus.digit_sel, bus.nibble_en, bus.frame_done, bus.nibble, nib_e);
    end
  endtask

  task automatic check_first_show(input string name);
    checks++;
    if (bus.digit_sel !== 4'b1110 || bus.nibble_en !== 1'b0 || bus.nibble !== 4'h0) begin
      failures++;
      $display("FAIL %s sel=%b want 1110 en=%b want 0 nib=%h want 0", name, bus.digit_sel, bus.nibble_en, bus.nibble);
    end
  endtask

  // checks one full frame from its frame_done cycle; up to two updates injected at (slot, tick)
  task automatic run_frame(input int us0, input int ut0, input logic [15:0] d0, input logic [3:0] m0,
                           input int us1, input int ut1, input logic [15:0] d1, input logic [3:0] m1);
    logic [3:0] one = 4'b0001;
    logic [3:0] prev_nib = 4'h0;
    logic [3:0] sel_e, nib_e;
    logic en_e, fd_e, nib_chk;
    bit pushed = 1'b0;
    int us[2] = '{us0, us1};
    int ut[2] = '{ut0, ut1};
    logic [15:0] dd[2] = '{d0, d1};
    logic [3:0] mm[2] = '{m0, m1};
    if (q.size() == 0) push_frame(last_d, last_m);
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < 10; t++) begin
        if (t == 0) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL queue_empty slot=%0d got none want an expected entry", s);
            cur = '0;
          end else cur = q.pop_front();
        end
        sel_e = t < 2 ? 4'hF : ~(one << s);
        en_e = t >= 2 ? cur.en : 1'b0;
        fd_e = s == 0 && t == 0;
        nib_e = t >= 2 ? cur.nib : prev_nib;
        nib_chk = t >= 2 || s > 0;
        checks++;
        if (bus.digit_sel !== sel_e || bus.nibble_en !== en_e || bus.frame_done !== fd_e || (nib_chk && bus.nibble !== nib_e)) begin
          failures++;
          $display("FAIL slot%0d_t%0d sel=%b want %b nib=%h want %h en=%b want %b fd=%b want %b",
                   s, t, bus.digit_sel, sel_e, bus.nibble, nib_e, bus.nibble_en, en_e, bus.frame_done, fd_e);
        end
        if (t == 9) prev_nib = cur.nib;
        bus.update = 1'b0;
        for (int k = 0; k < 2; k++)
          if (s == us[k] && t == ut[k]) begin
            bus.data = dd[k];
            bus.mask = mm[k];
            bus.update = 1'b1;
            if (pushed) repeat (4) void'(q.pop_back());
            push_frame(dd[k], mm[k]);
            pushed = 1'b1;
          end
        @(negedge clk);
      end
    bus.update = 1'b0;
  endtask

  task automatic sync_frame();
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.frame_done !== 1'b1) begin
      failures++;
      $display("FAIL frame_sync frame_done=%b want 1 within 100 cycles", bus.frame_done);
    end
  endtask

  task automatic test_reset();
    bus.data = '0;
    bus.mask = '0;
    bus.update = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_outputs", 4'h0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("blank_after_reset", 4'h0);
    @(negedge clk);
    check_first_show("first_show");
    bus.data = 16'h4321;
    bus.mask = 4'hF;
    bus.update = 1'b1;
    push_frame(16'h4321, 4'hF);
    @(negedge clk);
    bus.update = 1'b0;
    sync_frame();
  endtask

  task automatic test_basic();
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_mid_frame();
    run_frame(2, 5, 16'hABCD, 4'hF, -1, 0, '0, '0);
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_mask();
    run_frame(1, 3, 16'h8765, 4'b0101, -1, 0, '0, '0);
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_boundary();
    run_frame(3, 9, 16'h9F0E, 4'hF, -1, 0, '0, '0);
    checks++;
    if (dut.pending !== 1'b0) begin
      failures++;
      $display("FAIL boundary_pending pending=%b want 0", dut.pending);
    end
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_lzb();
    run_frame(1, 4, 16'h0030, 4'hF, -1, 0, '0, '0);
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 4, 16'h1111, 4'hF, 2, 6, 16'h2222, 4'hF);
    run_frame(-1, 0, '0, '0, -1, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_outputs", 4'h0);
    checks++;
    if (dut.pending !== 1'b0 || dut.shadow !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_state pending=%b shadow=%h want 0 and 0000", dut.pending, dut.shadow);
    end
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check_idle("mid_reset_blank", 4'h0);
    @(negedge clk);
    check_first_show("mid_reset_first_show");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_frame();
    test_mask();
    test_boundary();
    test_lzb();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
